seq_multiplier_n: RTL and testbench

Parametrised sequential shift-and-add multiplier, the next generation of the team's 8-bit `multiplier`. Adds a WIDTH parameter, a per-operation signed/unsigned mode, an asynchronous reset and a Busy status output. A single start pulse launches the operation, and Done marks a registered 2·WIDTH-bit product. It sits as an arithmetic leaf under a controller that issues St and waits for Done.

---
 rtl/seq_multiplier_n.sv | 63 ++++++
 tb/tb_seq_multiplier_n.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n: WIDTH-bit sequential shift-and-add multiplier with signed/unsigned mode and a Done pulse.
module seq_multiplier_n #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 St,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     Mplier,
  input  logic [WIDTH-1:0]     Mcand,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Result
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state, state_nx;
  logic [2*WIDTH:0]   p;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      cnt;
  logic               sgn;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   abs_mc, abs_mp;
  logic               last;
  // Signed operands are reduced to magnitudes; the sign is reapplied once in FIX.
  assign abs_mc = (Signed && Mcand[WIDTH-1]) ? -Mcand : Mcand;
  assign abs_mp = (Signed && Mplier[WIDTH-1]) ? -Mplier : Mplier;
  assign last   = cnt == CW'(WIDTH - 1);
  assign acc    = p[2*WIDTH:WIDTH] + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
  assign Busy   = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (St ? RUN : IDLE) :
               state == RUN  ? (last ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      p      <= '0;
      m      <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      Result <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= state == FIX;
      if (state == IDLE && St) begin
        m   <= abs_mc;
        p   <= {{(WIDTH+1){1'b0}}, abs_mp};
        sgn <= Signed & (Mcand[WIDTH-1] ^ Mplier[WIDTH-1]);
        cnt <= '0;
      end else if (state == RUN) begin
        p   <= {1'b0, acc, p[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
      end else if (state == FIX) begin
        Result <= sgn ? -p[2*WIDTH-1:0] : p[2*WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_seq_multiplier_n.sv
// tb_seq_multiplier_n: randomized and directed checks of seq_multiplier_n at WIDTH=8 and WIDTH=16.
module tb_seq_multiplier_n;
  logic        clk = 1'b0;
  logic        rst, st8, st16, sg;
  logic [15:0] mp, mc;
  logic        busy8, done8, busy16, done16;
  logic [15:0] res8;
  logic [31:0] res16;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_multiplier_n #(.WIDTH(8)) dut8 (
    .Clk(clk), .Rst(rst), .St(st8), .Signed(sg), .Mplier(mp[7:0]), .Mcand(mc[7:0]),
    .Busy(busy8), .Done(done8), .Result(res8));
  seq_multiplier_n #(.WIDTH(16)) dut16 (
    .Clk(clk), .Rst(rst), .St(st16), .Signed(sg), .Mplier(mp), .Mcand(mc),
    .Busy(busy16), .Done(done16), .Result(res16));

  function automatic logic [31:0] model(input int w, input bit s, input logic [15:0] a, input logic [15:0] b);
    longint ma, mb, sa, sb;
    ma = longint'(a) & ((longint'(1) << w) - 1);
    mb = longint'(b) & ((longint'(1) << w) - 1);
    sa = (s && ma[w-1]) ? ma - (longint'(1) << w) : ma;
    sb = (s && mb[w-1]) ? mb - (longint'(1) << w) : mb;
    return 32'((sa * sb) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic get_busy(input int w);
    return w == 8 ? busy8 : busy16;
  endfunction
  function automatic logic get_done(input int w);
    return w == 8 ? done8 : done16;
  endfunction
  function automatic logic [31:0] get_res(input int w);
    return w == 8 ? {16'h0, res8} : res16;
  endfunction

  task automatic set_st(input int w, input logic v);
    if (w == 8) st8 = v;
    else        st16 = v;
  endtask

  task automatic run_op(input int w, input bit s, input logic [15:0] a, input logic [15:0] b, input bit noise,
                        output logic [31:0] r, output int lat, output int busy_n, output int done_n);
    sg = s; mp = a; mc = b; set_st(w, 1'b1);
    @(negedge clk);
    set_st(w, 1'b0);
    lat = 0; busy_n = int'(get_busy(w)); done_n = 0;
    while (lat < 40) begin
      if (noise) begin
        mp = 16'($urandom); mc = 16'($urandom); sg = 1'($urandom); set_st(w, 1'($urandom));
      end
      @(negedge clk);
      lat++;
      busy_n += int'(get_busy(w));
      if (get_done(w)) begin
        done_n++;
        break;
      end
    end
    set_st(w, 1'b0);
    r = get_res(w);
  endtask

  task automatic count_dones(input int w, input int n, output int dn);
    dn = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dn += int'(get_done(w));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; st8 = 1'b1; st16 = 1'b1; sg = 1'b0; mp = 16'd3; mc = 16'd3;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, res8} !== 18'h0) begin
      errors++; $display("FAIL reset8 busy=%b done=%b result=%h want 0 0 0", busy8, done8, res8);
    end
    checks++;
    if ({busy16, done16, res16} !== 34'h0) begin
      errors++; $display("FAIL reset16 busy=%b done=%b result=%h want 0 0 0", busy16, done16, res16);
    end
    st8 = 1'b0; st16 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] r; int lat, bn, dn;
    run_op(8, 1'b0, 16'd10, 16'd5, 1'b0, r, lat, bn, dn);
    checks++;
    if (r !== 32'h32 || lat !== 9 || bn !== 9 || dn !== 1) begin
      errors++; $display("FAIL basic result=%h lat=%0d busy=%0d done=%0d want 32 9 9 1", r, lat, bn, dn);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bad;
    sg = 1'b0; mp = 16'd15; mc = 16'd4; st8 = 1'b1;
    @(negedge clk);
    mp = 16'd255; mc = 16'd255;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (res8 !== 16'd60 || lat !== 9) begin
      errors++; $display("FAIL b2b_first result=%h lat=%0d want 003c 9", res8, lat);
    end
    lat = 0; bad = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1 && (done8 !== 1'b0 || busy8 !== 1'b1)) bad += 100;
      if (!done8 && res8 !== 16'd60) bad++;
    end while (!done8 && lat < 40);
    st8 = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL b2b_hold bad=%0d want 0", bad);
    end
    checks++;
    if (res8 !== 16'hFE01 || lat !== 10) begin
      errors++; $display("FAIL b2b_second result=%h lat=%0d want fe01 10", res8, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_signed;
    logic [15:0] a [4] = '{16'hFD, 16'h80, 16'h80, 16'h00};
    logic [15:0] b [4] = '{16'h07, 16'h80, 16'h7F, 16'hFF};
    logic [15:0] e [4] = '{16'hFFEB, 16'h4000, 16'hC080, 16'h0000};
    logic [31:0] r; int lat, bn, dn;
    for (int i = 0; i < 4; i++) begin
      run_op(8, 1'b1, a[i], b[i], 1'b0, r, lat, bn, dn);
      checks++;
      if (r[15:0] !== e[i] || lat !== 9) begin
        errors++; $display("FAIL signed%0d result=%h lat=%0d want %h 9", i, r[15:0], lat, e[i]);
      end
    end
  endtask

  task automatic test_ignore_busy;
    logic [31:0] r; int lat, bn, dn, extra;
    run_op(8, 1'b1, 16'h9C, 16'h05, 1'b1, r, lat, bn, dn);
    checks++;
    if (r !== model(8, 1'b1, 16'h9C, 16'h05) || lat !== 9 || dn !== 1) begin
      errors++; $display("FAIL ignore_busy result=%h lat=%0d done=%0d want %h 9 1", r, lat, dn, model(8, 1'b1, 16'h9C, 16'h05));
    end
    count_dones(8, 15, extra);
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_busy_extra dones=%0d want 0", extra);
    end
  endtask

  task automatic test_abort;
    logic [31:0] r; int lat, bn, dn;
    sg = 1'b0; mp = 16'h23; mc = 16'h11; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, res8} !== 18'h0) begin
      errors++; $display("FAIL abort_now busy=%b done=%b result=%h want 0 0 0", busy8, done8, res8);
    end
    @(negedge clk);
    rst = 1'b0;
    count_dones(8, 20, dn);
    checks++;
    if (dn !== 0 || res8 !== 16'h0) begin
      errors++; $display("FAIL abort_after dones=%0d result=%h want 0 0", dn, res8);
    end
    run_op(8, 1'b0, 16'd6, 16'd7, 1'b0, r, lat, bn, dn);
    checks++;
    if (r !== 32'd42 || lat !== 9) begin
      errors++; $display("FAIL abort_restart result=%h lat=%0d want 2a 9", r, lat);
    end
  endtask

  task automatic test_width16;
    logic [31:0] r; int lat, bn, dn;
    run_op(16, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, r, lat, bn, dn);
    checks++;
    if (r !== 32'hFFFE0001 || lat !== 17 || bn !== 17) begin
      errors++; $display("FAIL w16_unsigned result=%h lat=%0d busy=%0d want fffe0001 17 17", r, lat, bn);
    end
    run_op(16, 1'b1, 16'hFFFE, 16'h0003, 1'b0, r, lat, bn, dn);
    checks++;
    if (r !== 32'hFFFFFFFA || lat !== 17) begin
      errors++; $display("FAIL w16_signed result=%h lat=%0d want fffffffa 17", r, lat);
    end
  endtask

  task automatic test_random;
    logic [31:0] r; int lat, bn, dn, w; bit s; logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      w = ($urandom % 2) ? 16 : 8;
      s = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      if (i % 8 == 0) a = (w == 8) ? 16'h80 : 16'h8000;
      run_op(w, s, a, b, 1'($urandom), r, lat, bn, dn);
      checks++;
      if (r !== model(w, s, a, b) || lat !== w + 1 || dn !== 1) begin
        errors++; $display("FAIL random%0d w=%0d s=%0d a=%h b=%h result=%h lat=%0d want %h %0d", i, w, s, a, b, r, lat, model(w, s, a, b), w + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_signed;
    test_ignore_busy;
    test_abort;
    test_width16;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
